// File: rtl/mem_controller.sv
// mem_controller: serialises 1/2/4-byte fetch (IF) and load/store (LS) accesses onto a byte-wide RAM/IO bus.
// Ports: clk_in/rst_in/rdy_in/clear control; mem_din/mem_dout/mem_a/mem_wr memory pins; io_buffer_full IO back-pressure;
//        if_valid/if_addr/if_ready/if_data fetch port; ls_valid/ls_wr/ls_size/ls_addr/ls_value/ls_ready/ls_res load/store port.
module mem_controller #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        ls_valid,
  input  logic        ls_wr,
  input  logic [2:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_value,
  output logic        ls_ready,
  output logic [31:0] ls_res
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic        owner, owner_nx;   // 0 = IF, 1 = LS
  logic        rr, rr_nx;         // 1 = LS wins the next tie
  logic [31:0] addr, addr_nx;
  logic [2:0]  size, size_nx;
  logic [31:0] value, value_nx;
  logic [2:0]  iss, iss_nx;       // READ: next byte to present; WRITE: byte being written
  logic [2:0]  cap, cap_nx;       // bytes captured so far
  logic        pres, pres_nx;     // an address is on mem_a this cycle
  logic        dvld, dvld_nx;     // mem_din carries byte 'cap' this cycle
  logic [31:0] rbuf, rbuf_nx;
  logic        wr_q, wr_nx;
  logic [31:0] mem_a_nx, if_data_nx, ls_res_nx;
  logic [7:0]  mem_dout_nx;
  logic        if_ready_nx, ls_ready_nx;
  logic [2:0]  nbytes, inext;
  logic [31:0] word;
  logic        io_busy, grant_if;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] s);
    case (s[1:0])
      2'd0:    return {{24{~s[2] & w[7]}}, w[7:0]};
      2'd1:    return {{16{~s[2] & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign nbytes  = size_bytes(size[1:0]);
  assign inext   = iss + 3'd1;
  assign io_busy = (addr[17:16] == IO_ADDR_HI) && io_buffer_full;
  // A held write must not reach the pins while paused; the retry happens after rdy_in returns.
  assign mem_wr  = wr_q & rdy_in;

  always_comb begin
    word = rbuf;
    word[{cap[1:0], 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_nx = state;  owner_nx = owner;  rr_nx = rr;
    addr_nx = addr;    size_nx = size;    value_nx = value;
    iss_nx = iss;      cap_nx = cap;      pres_nx = pres;   dvld_nx = dvld;
    rbuf_nx = rbuf;    mem_a_nx = mem_a;  mem_dout_nx = mem_dout;
    wr_nx = 1'b0;      if_ready_nx = 1'b0; ls_ready_nx = 1'b0;
    if_data_nx = if_data; ls_res_nx = ls_res;
    grant_if = 1'b0;

    if (!rdy_in) begin
      wr_nx = wr_q;
      if_ready_nx = if_ready;
      ls_ready_nx = ls_ready;
      if (state == READ) begin
        // The RAM keeps sampling the held address, so any in-flight byte is stale: rewind to re-present it.
        pres_nx = 1'b0;
        dvld_nx = 1'b0;
        iss_nx  = cap;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!clear && (if_valid || ls_valid)) begin
            grant_if = if_valid && (!ls_valid || !rr);
            rr_nx    = grant_if;
            owner_nx = !grant_if;
            addr_nx  = grant_if ? if_addr : ls_addr;
            size_nx  = grant_if ? 3'b010 : ls_size;
            value_nx = ls_value;
            mem_a_nx = grant_if ? if_addr : ls_addr;
            iss_nx   = 3'd1;
            cap_nx   = 3'd0;
            pres_nx  = 1'b1;
            dvld_nx  = 1'b0;
            rbuf_nx  = 32'd0;
            state_nx = READ;
            if (!grant_if && ls_wr) begin
              iss_nx      = 3'd0;
              pres_nx     = 1'b0;
              mem_dout_nx = ls_value[7:0];
              wr_nx       = !((ls_addr[17:16] == IO_ADDR_HI) && io_buffer_full);
              state_nx    = WRITE;
            end
          end
        end
        READ: begin
          if (clear) begin
            pres_nx  = 1'b0;
            dvld_nx  = 1'b0;
            state_nx = IDLE;
          end else begin
            dvld_nx = pres;
            if (iss < nbytes) begin
              mem_a_nx = addr + {29'd0, iss};
              iss_nx   = inext;
              pres_nx  = 1'b1;
            end else begin
              pres_nx = 1'b0;
            end
            if (dvld) begin
              rbuf_nx = word;
              cap_nx  = cap + 3'd1;
              if (cap == nbytes - 3'd1) begin
                state_nx = DONE;
                pres_nx  = 1'b0;
                dvld_nx  = 1'b0;
                if (owner) begin
                  ls_ready_nx = 1'b1;
                  ls_res_nx   = extend(word, size);
                end else begin
                  if_ready_nx = 1'b1;
                  if_data_nx  = word;
                end
              end
            end
          end
        end
        WRITE: begin
          if (wr_q) begin
            if (iss == nbytes - 3'd1) begin
              state_nx    = DONE;
              ls_ready_nx = 1'b1;
              ls_res_nx   = 32'd0;
            end else begin
              iss_nx      = inext;
              mem_a_nx    = addr + {29'd0, inext};
              mem_dout_nx = value[{inext[1:0], 3'b000} +: 8];
              wr_nx       = !io_busy;
            end
          end else begin
            wr_nx = !io_busy;
          end
        end
        default: state_nx = IDLE;  // DONE: ready is already high this cycle
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;   owner <= 1'b0;   rr <= 1'b0;
      addr <= 32'd0;   size <= 3'd0;    value <= 32'd0;
      iss <= 3'd0;     cap <= 3'd0;     pres <= 1'b0;   dvld <= 1'b0;
      rbuf <= 32'd0;   mem_a <= 32'd0;  mem_dout <= 8'd0; wr_q <= 1'b0;
      if_ready <= 1'b0; ls_ready <= 1'b0; if_data <= 32'd0; ls_res <= 32'd0;
    end else begin
      state <= state_nx; owner <= owner_nx; rr <= rr_nx;
      addr <= addr_nx;   size <= size_nx;   value <= value_nx;
      iss <= iss_nx;     cap <= cap_nx;     pres <= pres_nx; dvld <= dvld_nx;
      rbuf <= rbuf_nx;   mem_a <= mem_a_nx; mem_dout <= mem_dout_nx; wr_q <= wr_nx;
      if_ready <= if_ready_nx; ls_ready <= ls_ready_nx;
      if_data <= if_data_nx;   ls_res <= ls_res_nx;
    end
  end
endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Single-port memory controller that sequences 1/2/4-byte accesses over the byte-wide RAM/IO bus.
- Arbitrates between the instruction-fetch requester (IF, word reads only) and the load/store buffer requester (LS, reads and writes).
- Sits between the fetch unit / LSB cache-side interface and the top-level memory pins.
- Handles little-endian assembly, sign/zero extension, IO back-pressure and speculative-read abort on clear.

Parameters:
IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the IO region (writes there obey io_buffer_full)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, synchronous, active-low
rdy_in  input  1  pause when low: all state frozen, mem_wr forced 0
clear  input  1  pipeline flush; aborts any in-flight read
mem_din  input  8  RAM/IO read byte, valid one cycle after mem_a
mem_dout  output  8  write byte
mem_a  output  32  byte address
mem_wr  output  1  1 = write this cycle
io_buffer_full  input  1  IO sink cannot accept a write
if_valid  input  1  fetch request; held with if_addr until if_ready
if_addr  input  32  fetch word address
if_ready  output  1  one-cycle pulse: if_data valid
if_data  output  32  fetched word
ls_valid  input  1  LSB request; held stable until ls_ready
ls_wr  input  1  1 = store
ls_size  input  3  [1:0] 0 byte / 1 half / 2 word; [2] 1 = zero-extend (funct3 encoding)
ls_addr  input  32  byte address
ls_value  input  32  store data (low n bytes used)
ls_ready  output  1  one-cycle pulse: load result valid / store done
ls_res  output  32  extended load result (0 for stores)

Behaviour:
- Reset (rst_in=0 at posedge): state IDLE, mem_wr=0, mem_a=0, mem_dout=0, if_ready=0, ls_ready=0, if_data=0, ls_res=0, byte counter 0, round-robin flag = IF-first. Reset wins over rdy_in and clear.
- All outputs are registered.
- States: IDLE, READ, WRITE, DONE.
- IDLE: sample requests (clear low only).
  - One valid: grant it.
  - Both valid: grant per round-robin flag; flag toggles to the other requester after each grant.
  - Latch addr, size, value and owner; n = 1/2/4; counter k = 0.
  - Transition to READ (IF, or LS with ls_wr=0) or WRITE.
- Cycle numbering: C0 = acceptance cycle.
- READ: in Ck (k=1..n) mem_a = addr+k-1, mem_wr=0. Byte k-1 is captured from mem_din at the end of C(k+1), into bits [8(k-1)+7 : 8(k-1)].
  - After the last capture, go to DONE.
  - In C(n+2) the owner's ready=1 with data. LW: ready in C6; LB: ready in C3.
- Extension: size[2]=0 sign-extends from bit 8n-1; size[2]=1 zero-extends. IF is always a word.
- WRITE: in Ck mem_a = addr+k-1, mem_dout = value byte k-1, mem_wr=1.
  - If addr[17:16]==IO_ADDR_HI and io_buffer_full=1: the byte is held (mem_wr=0, k not advanced) until io_buffer_full=0.
  - After byte n-1, go to DONE; ls_ready=1 in the following cycle (C(n+1) without stalls).
- DONE: ready high exactly one cycle, then IDLE. No request is accepted in DONE, so the still-asserted valid is not re-accepted. Next acceptance is earliest the cycle after ready.
- clear=1:
  - During READ (either owner): abort next cycle, mem_wr=0, no ready pulse, back to IDLE.
  - In IDLE: no grant that cycle.
  - During WRITE or DONE: ignored; stores always complete.
- Address arithmetic is 32-bit with wrap-around (0xFFFFFFFF+1 = 0).
- rdy_in=0: counters, state and ready pulses hold; mem_wr driven 0. Capture of mem_din is deferred until rdy_in returns, i.e. the read address is re-presented.
- Idle output values: mem_wr=0; ready=0 outside DONE.

Test Plan:
- LW from 0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 in C1..C4; ls_res=0x44332211, ls_ready high only in C6.
- LB byte 0x80 -> ls_res=0xFFFFFF80; LBU -> 0x00000080; LH at 0x1FF (bytes 01,80) -> 0xFFFF8001, addr crosses to 0x200 correctly.
- SH 0xABCD1234 to 0x200 -> C1: a=0x200, dout=0x34, wr=1; C2: a=0x201, dout=0x12, wr=1; ls_ready in C3; no further mem_wr.
- if_valid and ls_valid held high together after reset -> IF granted first, LS second, IF third (alternating); no double acceptance of a request in its ready cycle.
- SB 0x41 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr=0 for 3 cycles, then one write of 0x41, ls_ready next cycle.
- clear in C2 of IF fetch -> no if_ready, IDLE next cycle, new fetch accepted; rst_in=0 mid-store -> mem_wr=0 and all outputs at reset values next cycle.
